// File: rtl/branch_update_ctrl_if.sv
// Resolve-stage handshake and predictor-table write bus for branch_update_ctrl.
// The controller uses the slave modport; the resolve stage / table side uses master.
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

interface branch_update_ctrl_if #(
  parameter int INDEX_BITS = 8,
  parameter int FIFO_DEPTH = 2
);
  localparam int TAG_W = `WORD_SIZE - INDEX_BITS;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                   res_valid;
  logic                   res_ready;
  logic [`WORD_SIZE-1:0]  res_pc;
  logic [`WORD_SIZE-1:0]  res_target;
  logic                   res_taken;
  logic                   res_is_branch;
  logic [INDEX_BITS-1:0]  cnt_index;
  logic [1:0]             cnt_rdata;
  logic                   cnt_we;
  logic [1:0]             cnt_wdata;
  logic                   btb_we;
  logic [INDEX_BITS-1:0]  btb_index;
  logic [TAG_W-1:0]       btb_tag;
  logic [`WORD_SIZE-1:0]  btb_target;
  logic                   init_done;
  logic [CNT_W-1:0]       pending;

  modport master (
    output res_valid, res_pc, res_target, res_taken, res_is_branch, cnt_rdata,
    input  res_ready, cnt_index, cnt_we, cnt_wdata, btb_we, btb_index, btb_tag,
           btb_target, init_done, pending
  );

  modport slave (
    input  res_valid, res_pc, res_target, res_taken, res_is_branch, cnt_rdata,
    output res_ready, cnt_index, cnt_we, cnt_wdata, btb_we, btb_index, btb_tag,
           btb_target, init_done, pending
  );
endinterface

// File: rtl/branch_update_ctrl.sv
// Write-side sequencer for the BTB and 2-bit counter tables: clears both after reset,
// then drains buffered resolved-branch records. Optional BP_TAKEN_ONLY_TARGET_EN.
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module branch_update_ctrl #(
  parameter int INDEX_BITS = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  branch_update_ctrl_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TAG_W = `WORD_SIZE - INDEX_BITS;

  typedef enum logic [1:0] {INIT, IDLE, READ, WRITE} state_t;

  state_t                state_q, state_d;
  logic [INDEX_BITS-1:0] init_cnt_q, init_cnt_d;
  logic                  walk_q;
  logic [PTR_W-1:0]      head_q, tail_q;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [1:0]            cnt_lat_q;

  logic [`WORD_SIZE-1:0] pc_mem  [FIFO_DEPTH];
  logic [`WORD_SIZE-1:0] tgt_mem [FIFO_DEPTH];
  logic                  tk_mem  [FIFO_DEPTH];
  logic                  br_mem  [FIFO_DEPTH];

  logic                  push, pop, ready;
  logic [`WORD_SIZE-1:0] head_pc, head_tgt;
  logic                  head_tk, head_br;
  logic [1:0]            cnt_next;

  logic [INDEX_BITS-1:0] cnt_index, btb_index;
  logic [TAG_W-1:0]      btb_tag;
  logic [`WORD_SIZE-1:0] btb_target;
  logic [1:0]            cnt_wdata;
  logic                  cnt_we, btb_we;

  assign head_pc  = pc_mem[head_q];
  assign head_tgt = tgt_mem[head_q];
  assign head_tk  = tk_mem[head_q];
  assign head_br  = br_mem[head_q];

  // No full-bypass: a popping cycle does not reopen a full buffer.
  assign ready   = (state_q != INIT) && (count_q < CNT_W'(FIFO_DEPTH));
  assign push    = bus.res_valid && ready;
  assign pop     = (state_q == WRITE);
  assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

  always_comb begin
    cnt_next = 2'b11;
    if (head_br) begin
      if (head_tk) cnt_next = (cnt_lat_q == 2'b11) ? 2'b11 : cnt_lat_q + 2'b01;
      else         cnt_next = (cnt_lat_q == 2'b00) ? 2'b00 : cnt_lat_q - 2'b01;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    cnt_index  = '0;
    btb_index  = '0;
    btb_tag    = '0;
    btb_target = '0;
    cnt_wdata  = '0;
    cnt_we     = 1'b0;
    btb_we     = 1'b0;
    unique case (state_q)
      INIT: begin
        // walk_q holds the strobes off while reset is asserted
        if (walk_q) begin
          cnt_we     = 1'b1;
          btb_we     = 1'b1;
          cnt_index  = init_cnt_q;
          btb_index  = init_cnt_q;
          btb_target = '1;
          init_cnt_d = init_cnt_q + 1'b1;
          if (init_cnt_q == '1) state_d = IDLE;
        end
      end
      IDLE: begin
        if (count_q != '0) state_d = READ;
      end
      READ: begin
        cnt_index = head_pc[INDEX_BITS-1:0];
        btb_index = head_pc[INDEX_BITS-1:0];
        state_d   = WRITE;
      end
      WRITE: begin
        cnt_index  = head_pc[INDEX_BITS-1:0];
        btb_index  = head_pc[INDEX_BITS-1:0];
        btb_tag    = head_pc[`WORD_SIZE-1:INDEX_BITS];
        btb_target = head_tgt;
        cnt_wdata  = cnt_next;
        cnt_we     = 1'b1;
`ifdef BP_TAKEN_ONLY_TARGET_EN
        btb_we     = !head_br || head_tk;
`else
        btb_we     = 1'b1;
`endif
        state_d    = (count_d != '0) ? READ : IDLE;
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      walk_q     <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      cnt_lat_q  <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      walk_q     <= 1'b1;
      count_q    <= count_d;
      if (push) tail_q <= tail_q + 1'b1;
      if (pop)  head_q <= head_q + 1'b1;
      if (state_q == READ) cnt_lat_q <= bus.cnt_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail_q]  <= bus.res_pc;
      tgt_mem[tail_q] <= bus.res_target;
      tk_mem[tail_q]  <= bus.res_taken;
      br_mem[tail_q]  <= bus.res_is_branch;
    end
  end

  assign bus.res_ready  = ready;
  assign bus.init_done  = (state_q != INIT);
  assign bus.pending    = count_q;
  assign bus.cnt_index  = cnt_index;
  assign bus.cnt_we     = cnt_we;
  assign bus.cnt_wdata  = cnt_wdata;
  assign bus.btb_we     = btb_we;
  assign bus.btb_index  = btb_index;
  assign bus.btb_tag    = btb_tag;
  assign bus.btb_target = btb_target;
endmodule

// File: tb/tb_branch_update_ctrl.sv
// Bench for branch_update_ctrl: timestamp-based reference model of the table-write
// stream plus directed records with hand-computed table contents.
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module tb_branch_update_ctrl;
  localparam int IB = 8;
  localparam int FD = 2;
  localparam int NENT = 1 << IB;
`ifdef BP_TAKEN_ONLY_TARGET_EN
  localparam bit TAKEN_ONLY = 1'b1;
`else
  localparam bit TAKEN_ONLY = 1'b0;
`endif

  typedef struct {
    logic [15:0] pc;
    logic [15:0] tgt;
    logic        tk;
    logic        br;
    int          w;
  } rec_t;

  logic clk;
  logic reset_n;
  int   checks = 0;
  int   failures = 0;

  branch_update_ctrl_if #(.INDEX_BITS(IB), .FIFO_DEPTH(FD)) bif ();

  branch_update_ctrl #(.INDEX_BITS(IB), .FIFO_DEPTH(FD)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model state: cyc = edges since reset release; a record writes during cycle w
  int          cyc = 0;
  int          acc_edge = -1;
  int          last_w = 0;
  bit          have_last = 1'b0;
  rec_t        rec_q[$];
  logic [1:0]  ref_cnt [NENT];
  // table storage as seen by the predictor, written by DUT strobes
  logic [1:0]  st_cnt [NENT];
  logic [7:0]  st_tag [NENT];
  logic [15:0] st_tgt [NENT];

  int wr_log[$];
  int init_strb_cnt = 0;
  int ready_low_cnt = 0;

  assign bif.cnt_rdata = st_cnt[bif.cnt_index];

  function automatic int sat_next(int v, logic tk, logic br);
    if (!br) return 3;
    if (tk)  return (v >= 3) ? 3 : v + 1;
    return (v <= 0) ? 0 : v - 1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        cyc = 0;
        acc_edge = -1;
        have_last = 1'b0;
        rec_q.delete();
        for (int i = 0; i < NENT; i++) ref_cnt[i] = 2'b00;
      end else begin
        int e;
        e = cyc + 1;
        if (bif.res_valid && cyc >= NENT + 1 && rec_q.size() < FD) begin
          rec_t r;
          r.pc = bif.res_pc; r.tgt = bif.res_target;
          r.tk = bif.res_taken; r.br = bif.res_is_branch;
          r.w = (have_last && e <= last_w + 1) ? last_w + 2 : e + 2;
          last_w = r.w;
          have_last = 1'b1;
          acc_edge = e;
          rec_q.push_back(r);
        end
        if (rec_q.size() > 0 && rec_q[0].w + 1 == e) begin
          ref_cnt[rec_q[0].pc[7:0]] = 2'(sat_next(int'(ref_cnt[rec_q[0].pc[7:0]]), rec_q[0].tk, rec_q[0].br));
          void'(rec_q.pop_front());
        end
        if (bif.cnt_we) st_cnt[bif.cnt_index] = bif.cnt_wdata;
        if (bif.btb_we) begin
          st_tag[bif.btb_index] = bif.btb_tag;
          st_tgt[bif.btb_index] = bif.btb_target;
        end
        cyc = e;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      begin
        bit exp_init, exp_done, exp_wr, exp_bwe;
        exp_init = (cyc >= 1 && cyc <= NENT);
        exp_done = (cyc >= NENT + 1);
        exp_wr   = (rec_q.size() > 0) && (rec_q[0].w == cyc);
        exp_bwe  = exp_init || (exp_wr && (!TAKEN_ONLY || !rec_q[0].br || rec_q[0].tk));
        chk("cnt_we", bif.cnt_we, exp_init || exp_wr);
        chk("btb_we", bif.btb_we, exp_bwe);
        chk("init_done", bif.init_done, exp_done);
        chk("res_ready", bif.res_ready, exp_done && rec_q.size() < FD);
        chk("pending", bif.pending, rec_q.size());
        if (cyc == 0) begin
          chk("reset_idx", {bif.cnt_index, bif.btb_index}, 0);
          chk("reset_bus", {bif.btb_tag, bif.btb_target, bif.cnt_wdata}, 0);
        end
        if (exp_init) begin
          chk("init_index", {bif.cnt_index, bif.btb_index}, {8'(cyc - 1), 8'(cyc - 1)});
          chk("init_data", {bif.btb_tag, bif.btb_target, bif.cnt_wdata}, {8'h00, 16'hFFFF, 2'b00});
        end
        if (exp_wr) begin
          rec_t r;
          r = rec_q[0];
          chk("wr_index", {bif.cnt_index, bif.btb_index}, {r.pc[7:0], r.pc[7:0]});
          chk("wr_tag_tgt", {bif.btb_tag, bif.btb_target}, {r.pc[15:8], r.tgt});
          chk("wr_cnt", bif.cnt_wdata, sat_next(int'(ref_cnt[r.pc[7:0]]), r.tk, r.br));
        end
        if (bif.cnt_we && !bif.init_done) init_strb_cnt++;
        if (bif.cnt_we && bif.init_done) wr_log.push_back(cyc);
        if (bif.init_done && !bif.res_ready) ready_low_cnt++;
      end
    end
  end

  task automatic send(input logic [15:0] pc, input logic [15:0] tgt, input logic tk, input logic br);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    bif.res_valid = 1'b1;
    bif.res_pc = pc; bif.res_target = tgt;
    bif.res_taken = tk; bif.res_is_branch = br;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (acc_edge == cyc) begin
        ok = 1'b1;
        break;
      end
    end
    chk("accept", ok, 1'b1);
  endtask

  task automatic idle();
    @(negedge clk);
    bif.res_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rec_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain", ok, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_init();
    bit ok;
    int s0;
    ok = 1'b0;
    s0 = init_strb_cnt;
    for (int i = 0; i < NENT + 20; i++) begin
      @(negedge clk);
      if (cyc >= NENT + 1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("init_finish", ok, 1'b1);
    chk("init_strobe_cycles", init_strb_cnt - s0, NENT);
    chk("ready_after_init", bif.res_ready, 1'b1);
  endtask

  initial begin
    int mark, low0;
    bit ok;
    reset_n = 1'b0;
    bif.res_valid = 1'b0;
    bif.res_pc = '0; bif.res_target = '0;
    bif.res_taken = 1'b0; bif.res_is_branch = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_strobes", {bif.cnt_we, bif.btb_we}, 2'b00);
    chk("rst_ready_done", {bif.res_ready, bif.init_done}, 2'b00);
    reset_n = 1'b1;
    wait_init();

    // 0x34 counter: 0 -> 1, then the 0x1234 record reads 1 and writes 2
    send(16'h5534, 16'h5500, 1'b1, 1'b1);
    idle();
    drain();
    send(16'h1234, 16'h1240, 1'b1, 1'b1);
    idle();
    drain();
    chk("lit_1234_cnt", st_cnt[8'h34], 2'b10);
    chk("lit_1234_tag", st_tag[8'h34], 8'h12);
    chk("lit_1234_tgt", st_tgt[8'h34], 16'h1240);

    send(16'h1234, 16'h1240, 1'b1, 1'b1);
    send(16'h1234, 16'h1240, 1'b1, 1'b1);
    send(16'h0251, 16'h0300, 1'b0, 1'b1);
    send(16'h0352, 16'h0400, 1'b0, 1'b0);
    idle();
    drain();
    chk("lit_sat_hi", st_cnt[8'h34], 2'b11);
    chk("lit_sat_lo", st_cnt[8'h51], 2'b00);
    chk("lit_nt_target", st_tgt[8'h51], TAKEN_ONLY ? 16'hFFFF : 16'h0300);
    chk("lit_jump", st_cnt[8'h52], 2'b11);

    mark = wr_log.size();
    low0 = ready_low_cnt;
    send(16'h0460, 16'h0470, 1'b1, 1'b1);
    send(16'h0561, 16'h0570, 1'b1, 1'b1);
    send(16'h0662, 16'h0670, 1'b1, 1'b1);
    idle();
    drain();
    chk("burst_writes", wr_log.size() - mark, 3);
    if (wr_log.size() - mark >= 3) begin
      chk("burst_gap1", wr_log[mark + 1] - wr_log[mark], 2);
      chk("burst_gap2", wr_log[mark + 2] - wr_log[mark + 1], 2);
    end
    chk("burst_ready_dropped", (ready_low_cnt - low0) > 0, 1'b1);
    chk("lit_burst_order", {st_tgt[8'h60], st_tgt[8'h61], st_tgt[8'h62]}, {16'h0470, 16'h0570, 16'h0670});

    send(16'h0005, 16'h0010, 1'b1, 1'b1);
    send(16'h0005, 16'h0010, 1'b1, 1'b1);
    idle();
    drain();
    chk("lit_same_index", st_cnt[8'h05], 2'b10);

    // reset asserted in the middle of a WRITE cycle
    send(16'h0777, 16'h0780, 1'b0, 1'b1);
    idle();
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rec_q.size() > 0 && rec_q[0].w == cyc) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("reach_write", ok, 1'b1);
    chk("nt_write_strobes", {bif.btb_we, bif.cnt_we}, {!TAKEN_ONLY, 1'b1});
    #2 reset_n = 1'b0;
    #1;
    chk("async_strobes", {bif.cnt_we, bif.btb_we}, 2'b00);
    chk("async_pending", bif.pending, 0);
    chk("async_done", bif.init_done, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wait_init();
    chk("lit_cleared", {st_cnt[8'h34], st_tgt[8'h34]}, {2'b00, 16'hFFFF});
    send(16'h1234, 16'h1240, 1'b1, 1'b1);
    idle();
    drain();
    chk("lit_post_reset", st_cnt[8'h34], 2'b01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
